// File: rtl/opsum_writeback.sv
// opsum_writeback: drains the conv-unit opsum stream into the GLB, raw or int8-requantized.
// Optional build macro RELU_ENABLE_EN clamps negative requantized values to zero.
module opsum_writeback #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              final_mode,
    input  logic [3:0]        shift,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              glb_we,
    output logic [ADDR_W-1:0] glb_addr,
    output logic [31:0]       glb_wdata,
    input  logic              glb_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              final_q, final_d;
    logic [3:0]        shift_q, shift_d;
    logic [15:0]       pack_q, pack_d;
    logic              pack_vld_q, pack_vld_d;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              full;
    logic              empty;
    logic              accept;
    logic              pop;
    logic              push;
    logic [31:0]       push_data;
    logic [7:0]        q0;
    logic [7:0]        q1;

    // Round-half-up arithmetic shift, then saturate to int8 (or [0,127] with ReLU).
    function automatic logic [7:0] requant(input logic [15:0] p, input logic [3:0] sh);
        logic signed [16:0] rnd;
        logic signed [16:0] sum;
        logic signed [16:0] r;
        rnd = (sh == 4'd0) ? 17'sd0 : (17'sd1 <<< (sh - 4'd1));
        sum = $signed({p[15], p}) + rnd;
        r   = sum >>> sh;
`ifdef RELU_ENABLE_EN
        if (r < 17'sd0) r = 17'sd0;
`endif
        if (r > 17'sd127) return 8'h7f;
        else if (r < -17'sd128) return 8'h80;
        else return r[7:0];
    endfunction

    assign q0 = requant(in_data[15:0], shift_q);
    assign q1 = requant(in_data[31:16], shift_q);

    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = (state_q == S_RUN) && !full && (rem_q != '0);
    assign accept    = in_valid && in_ready;
    assign glb_we    = !empty;
    assign pop       = glb_we && glb_ready;
    assign glb_wdata = empty ? 32'h0 : mem_q[rd_q];
    assign glb_addr  = addr_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

    // Job control: config latch, input counting, packing, flush and completion.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        final_d    = final_q;
        shift_d    = shift_q;
        pack_d     = pack_q;
        pack_vld_d = pack_vld_q;
        push       = 1'b0;
        push_data  = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d    = S_RUN;
                        rem_d      = word_count;
                        addr_d     = base_addr;
                        final_d    = final_mode;
                        shift_d    = shift;
                        pack_vld_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    rem_d = rem_q - ADDR_W'(1);
                    if (!final_q) begin
                        push      = 1'b1;
                        push_data = in_data;
                    end else if (!pack_vld_q) begin
                        pack_d     = {q1, q0};
                        pack_vld_d = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_data  = {q1, q0, pack_q};
                        pack_vld_d = 1'b0;
                    end
                end else if (rem_q == '0 && pack_vld_q && !full) begin
                    push       = 1'b1;
                    push_data  = {16'h0, pack_q};
                    pack_vld_d = 1'b0;
                end
                if (rem_q == '0 && !pack_vld_q &&
                    (empty || (cnt_q == CNT_W'(1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (pop) addr_d = addr_q + ADDR_W'(1);
    end

    // Output FIFO bookkeeping; simultaneous push and pop keep occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) rd_d = rd_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards any in-flight job at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            addr_q     <= '0;
            final_q    <= 1'b0;
            shift_q    <= '0;
            pack_q     <= '0;
            pack_vld_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
            shift_q    <= shift_d;
            pack_q     <= pack_d;
            pack_vld_q <= pack_vld_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_opsum_writeback.sv
// tb_opsum_writeback: directed bench for opsum_writeback.
// Hand-computed expectations; RELU_ENABLE_EN selects final-mode values.
module tb_opsum_writeback;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] word_count;
    logic        final_mode;
    logic [3:0]  shift;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        glb_we;
    logic [11:0] glb_addr;
    logic [31:0] glb_wdata;
    logic        glb_ready;
    logic        busy;
    logic        done;

    opsum_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .final_mode (final_mode),
        .shift      (shift),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .glb_we     (glb_we),
        .glb_addr   (glb_addr),
        .glb_wdata  (glb_wdata),
        .glb_ready  (glb_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc = 0;
    int          dn = 0;
    int          nw = 0;
    int          first_we = -1;
    int          first_acc = -1;
    int          last_wr = -1;
    int          done_cyc = -1;
    logic [31:0] wv [16];
    logic [11:0] wa [$];
    logic [31:0] wd [$];
    logic [31:0] exp2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        #1;
        if (glb_we && first_we < 0) first_we = cyc;
        if (glb_we && glb_ready) begin
            wa.push_back(glb_addr);
            wd.push_back(glb_wdata);
            last_wr = cyc;
        end
        if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            acc++;
        end
        if (done) begin
            dn++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_job(input logic fm, input logic [3:0] sh,
                             input logic [11:0] base, input logic [11:0] n);
        wa.delete();
        wd.delete();
        acc = 0;
        dn = 0;
        first_we = -1;
        first_acc = -1;
        nw = int'(n);
        start = 1'b1;
        final_mode = fm;
        shift = sh;
        base_addr = base;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic drive();
        in_valid = (acc < nw);
        in_data = (acc < nw && acc < 16) ? wv[acc] : 32'h0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && dn == 0; i++) begin
            drive();
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        final_mode = 1'b0;
        shift = '0;
        in_valid = 1'b0;
        in_data = '0;
        glb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {in_ready, glb_we, busy, done, glb_addr, glb_wdata}, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        // 1: raw mode, three words
        wv[0] = 32'h00010002;
        wv[1] = 32'h00030004;
        wv[2] = 32'h00050006;
        start_job(1'b0, 4'd0, 12'h010, 12'd3);
        check("t1_busy", busy, 1);
        drain(30);
        check("t1_nwrites", wa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", wa[i], 64'h010 + i);
            check("t1_data", wd[i], wv[i]);
        end
        check("t1_latency", first_we - first_acc, 1);
        check("t1_done_once", dn, 1);
        check("t1_done_after", done_cyc > last_wr, 1);
        check("t1_idle", {busy, glb_we}, 0);

        // 2: final mode pack of two words
        wv[0] = 32'h0010FFF0;
        wv[1] = 32'h7FFF8000;
`ifdef RELU_ENABLE_EN
        exp2 = 32'h7F000400;
`else
        exp2 = 32'h7F8004FC;
`endif
        start_job(1'b1, 4'd2, 12'h100, 12'd2);
        drain(30);
        check("t2_nwrites", wa.size(), 1);
        check("t2_addr", wa[0], 12'h100);
        check("t2_data", wd[0], exp2);
        check("t2_done", dn, 1);

        // 3: backpressure fills the FIFO
        for (int i = 0; i < 8; i++) wv[i] = 32'hA000_0000 + i;
        glb_ready = 1'b0;
        start_job(1'b0, 4'd0, 12'h040, 12'd8);
        for (int i = 0; i < 10; i++) begin
            drive();
            tick();
        end
        check("t3_accepted", acc, 4);
        check("t3_in_ready", in_ready, 0);
        check("t3_no_write", wa.size(), 0);
        glb_ready = 1'b1;
        drain(40);
        check("t3_nwrites", wa.size(), 8);
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            check("t3_addr", wa[i], 64'h040 + i);
            check("t3_data", wd[i], 32'hA000_0000 + i);
        end
        check("t3_done", dn, 1);

        // 4: odd word_count flushes the half pack
        for (int i = 0; i < 3; i++) wv[i] = 32'h00050005;
        start_job(1'b1, 4'd0, 12'h200, 12'd3);
        drain(30);
        check("t4_nwrites", wa.size(), 2);
        check("t4_addr0", wa[0], 12'h200);
        check("t4_data0", wd[0], 32'h05050505);
        check("t4_addr1", wa[1], 12'h201);
        check("t4_data1", wd[1], 32'h00000505);
        check("t4_done", dn, 1);

        // 5: reset in the middle of a job
        for (int i = 0; i < 4; i++) wv[i] = 32'hC0DE_0000 + i;
        glb_ready = 1'b0;
        start_job(1'b0, 4'd0, 12'h030, 12'd4);
        for (int i = 0; i < 10 && acc < 2; i++) begin
            drive();
            tick();
        end
        check("t5_accepted", acc, 2);
        in_valid = 1'b0;
        reset = 1'b0;
        glb_ready = 1'b1;
        #1;
        check("t5_reset_out", {glb_we, busy, in_ready}, 0);
        tick();
        tick();
        check("t5_no_write", wa.size(), 0);
        reset = 1'b1;
        tick();
        wv[0] = 32'hDEADBEEF;
        start_job(1'b0, 4'd0, 12'h020, 12'd1);
        drain(20);
        check("t5_nwrites", wa.size(), 1);
        check("t5_addr", wa[0], 12'h020);
        check("t5_data", wd[0], 32'hDEADBEEF);

        // 6: empty job, then address wrap
        start_job(1'b0, 4'd0, 12'h123, 12'd0);
        check("t6_done_now", {done, glb_we, busy}, 3'b100);
        tick();
        check("t6_done_gone", done, 0);
        check("t6_no_write", wa.size(), 0);
        wv[0] = 32'hAAAA5555;
        wv[1] = 32'h12345678;
        start_job(1'b0, 4'd0, 12'hFFF, 12'd2);
        drain(20);
        check("t6_nwrites", wa.size(), 2);
        check("t6_addr0", wa[0], 12'hFFF);
        check("t6_data0", wd[0], 32'hAAAA5555);
        check("t6_addr1", wa[1], 12'h000);
        check("t6_data1", wd[1], 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opsum_writeback.md
Name: opsum_writeback

Overview:
Downstream stage of the conv unit. It consumes the 32-bit opsum stream emitted during the conv unit's OPSUM_OUT phase. Each word carries two signed 16-bit psums.
- Raw mode: writes psum words back to the GLB unchanged, as partial sums for the next channel group.
- Final mode: requantizes each psum to int8 and packs four per word before writing.
- A small output FIFO decouples the conv-side stream from GLB write backpressure.

Parameters:
ADDR_W, 12, GLB word-address width
FIFO_DEPTH, 4, output FIFO depth in 32-bit words (power of two, >=2)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; latches base_addr, word_count, final_mode, shift
base_addr  input  ADDR_W  first GLB write address
word_count  input  ADDR_W  number of input opsum words to consume
final_mode  input  1  1 = requantize+pack int8; 0 = raw psum passthrough
shift  input  4  arithmetic right-shift amount for requantization
in_valid  input  1  opsum word valid
in_data  input  32  [15:0] lane0 psum, [31:16] lane1 psum, signed
in_ready  output  1  word accepted when in_valid && in_ready
glb_we  output  1  write request
glb_addr  output  ADDR_W  write address
glb_wdata  output  32  write data
glb_ready  input  1  write accepted when glb_we && glb_ready
busy  output  1  job in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: in_ready=0, glb_we=0, glb_addr=0, glb_wdata=0, busy=0, done=0. FIFO emptied, pack register and counters cleared.
- States:
  - IDLE: start with word_count!=0 latches config, goes to RUN, and sets busy=1 next cycle. start with word_count==0 goes to DONE.
  - RUN: after all inputs are accepted, any pending half-pack is flushed, the FIFO is empty and the last write is accepted, goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- in_ready = RUN && FIFO not full && remaining input count > 0. Words beyond word_count are never accepted.
- Raw mode: each accepted word is pushed to the FIFO unchanged.
- Final mode, per lane, in 17-bit signed arithmetic:
  - r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
  - Saturate r to [-128,127].
  - Word k even: lane0 goes to byte0, lane1 to byte1; the pair is held in the pack register.
  - Word k odd: lane0 goes to byte2, lane1 to byte3, and the packed word is pushed.
  - Odd word_count: after the last word, the pending half is pushed with bytes 3:2 = 0.
- FIFO:
  - glb_we = FIFO not empty; glb_wdata = FIFO head.
  - Pop on glb_we && glb_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - No push occurs when full, because in_ready is low.
- Address: glb_addr = base_addr + output-word index, modulo 2^ADDR_W (wraps 0xFFF to 0x000 for ADDR_W=12). Writes are strictly in order.
- Latency: a word accepted at cycle t that completes an output word (raw word, or odd word in final mode) drives glb_we at t+1 when the FIFO was empty.
- With glb_ready held high, the raw-mode sustained rate is 1 word/cycle.
- Reset mid-operation: all state is discarded immediately and outputs return to reset values. No write completes after reset.

Optional Feature:
Macro RELU_ENABLE_EN.
- Defined: in final mode, negative r is clamped to 0 before saturation (output range [0,127]). Raw mode is unaffected.
- Undefined: signed saturation to [-128,127] only.

Test Plan:
1. Raw mode, base 0x010, word_count=3, words 0x00010002/0x00030004/0x00050006, glb_ready=1 -> writes to 0x010, 0x011, 0x012 with identical data; first glb_we 1 cycle after first accept; done pulses once after the third write.
2. Final mode, shift=2, words 0x0010FFF0 then 0x7FFF8000 -> single write 0x7F8004FC. With RELU_ENABLE_EN -> 0x7F000400.
3. Backpressure, raw mode, word_count=8, glb_ready=0 for 10 cycles with in_valid held -> exactly 4 words accepted, then in_ready=0. After glb_ready=1, all 8 words are written in order to consecutive addresses with no loss or duplication.
4. Final mode, word_count=3, shift=0, all psums=5 -> 2 writes: 0x05050505, then 0x00000505.
5. Reset asserted after 2 raw words accepted with glb_ready=0 -> glb_we, busy, in_ready=0 next edge. A new start with base 0x020 and word_count=1 writes only to 0x020.
6. start with word_count=0 -> done the next cycle, no glb_we. Raw mode, base 0xFFF, word_count=2 -> addresses 0xFFF then 0x000.
